// File: rtl/logit_if.sv
// logit_if: request/response bundle for the logit block.
//   i_in_valid : input sample valid this cycle
//   i_y        : probability, unsigned Q0.16
//   o_x        : logit result, two's-complement Q3.5
//   o_out_valid: o_x valid this cycle
// master drives the probability and consumes the result; slave is the block.
interface logit_if;
  logic        i_in_valid;
  logic [15:0] i_y;
  logic [7:0]  o_x;
  logic        o_out_valid;

  modport master (output i_in_valid, i_y, input o_x, o_out_valid);
  modport slave  (input i_in_valid, i_y, output o_x, o_out_valid);
endinterface

// File: rtl/logit.sv
// logit: inverse of the PWL sigmoid. Maps a Q0.16 probability to the Q3.5
// x whose PWL sigmoid is that probability. Two register stages, one result
// per clock, no backpressure. Built only from counted cells; the summed
// transistor count of every cell instance is reported on `number`.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : logit_if.slave (i_in_valid, i_y in; o_x, o_out_valid out)
//   number : total transistor count, constant
module logit (
  input  logic        clk,
  input  logic        rst_n,
  logit_if.slave      bus,
  output logic [50:0] number
);
  // ---------------- stage 1: fold and classify ----------------
  // y' = i_y when i_y[15]=1, else ~i_y; XNOR against the sign bit does both
  // (bit 15 folds to a constant 1).
  logic [15:0]      yf;
  logic [15:0][50:0] n_fold;
  for (genvar i = 0; i < 16; i++) begin : g_fold
    XNOR2 u_x (.a(bus.i_y[i]), .b(bus.i_y[15]), .y(yf[i]), .number(n_fold[i]));
  end

  // Region C: y'[14] & y'[13:10] >= 4'b1011. Region B: y'[14] & ~C. A: rest.
  logic neg_d, r_lo, r_mid, r_hi, reg_c, nreg_c, reg_b;
  logic [6:0][50:0] n_s1;
  INV  u_neg  (.a(bus.i_y[15]),       .y(neg_d),  .number(n_s1[0]));
  AND2 u_rlo  (.a(yf[11]), .b(yf[10]), .y(r_lo),   .number(n_s1[1]));
  OR2  u_rmid (.a(yf[12]), .b(r_lo),   .y(r_mid),  .number(n_s1[2]));
  AND2 u_rhi  (.a(yf[14]), .b(yf[13]), .y(r_hi),   .number(n_s1[3]));
  AND2 u_rc   (.a(r_hi),   .b(r_mid),  .y(reg_c),  .number(n_s1[4]));
  INV  u_rnc  (.a(reg_c),              .y(nreg_c), .number(n_s1[5]));
  AND2 u_rb   (.a(yf[14]), .b(nreg_c), .y(reg_b),  .number(n_s1[6]));

  // Stage-1 bank: {region[1:0] (A=00,B=01,C=10), neg, y'}
  logic [18:0] s1_q;
  logic [2:0][50:0] n_reg;
  REGP #(.W(19)) u_s1 (
    .clk(clk), .rst_n(rst_n), .d({reg_c, reg_b, neg_d, yf}),
    .q(s1_q), .number(n_reg[0])
  );

  // Valid shift register, independent of the data banks.
  logic [2:0] vld_pipe;
  assign vld_pipe[0] = bus.i_in_valid;
  REGP #(.W(2)) u_vld (
    .clk(clk), .rst_n(rst_n), .d(vld_pipe[1:0]), .q(vld_pipe[2:1]),
    .number(n_reg[1])
  );
  assign bus.o_out_valid = vld_pipe[2];

  // ---------------- stage 2: magnitude, saturate, sign ----------------
  logic [15:0] y1;
  logic        neg1;
  logic [1:0]  rg1;
  assign y1   = s1_q[15:0];
  assign neg1 = s1_q[16];
  assign rg1  = s1_q[18:17];

  // y'[15] is always 1 and the low six bits are below every region's LSB.
  logic unused_y1;
  assign unused_y1 = ^{y1[15], y1[5:0]};

  // A: (y'-0x8000)>>9 = y'[13:9].
  // B: (y'-0xA000)>>8 = 0x20 + y'[13:8]; y'[13:8] <= 0x2B so the add only
  //    touches bits 6:5.
  // C: (y'-0xD800)>>6 = y'[13:6] - 0x60; y'[13:11] is 101..111 here, so the
  //    top three bits become {y12&y11, ~(y12&y11), ~y11}.
  logic ny13, ny11, nneg, c7, c6;
  logic [4:0][50:0] n_s2;
  INV   u_n13  (.a(y1[13]),              .y(ny13), .number(n_s2[0]));
  INV   u_n11  (.a(y1[11]),              .y(ny11), .number(n_s2[1]));
  INV   u_nneg (.a(neg1),                .y(nneg), .number(n_s2[2]));
  AND2  u_c7   (.a(y1[12]), .b(y1[11]),  .y(c7),   .number(n_s2[3]));
  NAND2 u_c6   (.a(y1[12]), .b(y1[11]),  .y(c6),   .number(n_s2[4]));

  logic [7:0] a_v, b_v, c_v, m_ab, mag;
  assign a_v = {3'b000, y1[13:9]};
  assign b_v = {1'b0, y1[13], ny13, y1[12:8]};
  assign c_v = {c7, c6, ny11, y1[10:6]};

  logic [7:0][50:0] n_mab, n_mc;
  for (genvar k = 0; k < 8; k++) begin : g_mag
    MUX2 u_ab (.a(a_v[k]),  .b(b_v[k]), .s(rg1[0]), .y(m_ab[k]), .number(n_mab[k]));
    MUX2 u_c  (.a(m_ab[k]), .b(c_v[k]), .s(rg1[1]), .y(mag[k]),  .number(n_mc[k]));
  end

  // mag >= 128 only happens in region C. Clamp to 0x7F when positive and to
  // 0x80 when negative; 0x80 negates to itself, giving -4.0.
  logic [7:0] sat;
  logic [7:0][50:0] n_sat;
  AND2 u_sat7 (.a(mag[7]), .b(neg1), .y(sat[7]), .number(n_sat[7]));
  for (genvar k = 0; k < 7; k++) begin : g_sat
    MUX2 u_m (.a(mag[k]), .b(nneg), .s(mag[7]), .y(sat[k]), .number(n_sat[k]));
  end

  // Two's-complement negate without a carry chain: keep bits up to and
  // including the lowest 1, invert every bit above it. t[k] = |sat[k-1:0].
  // A zero magnitude stays 0x00, so negative zero is free.
  logic [7:1] t, flip;
  logic [7:0] x_d;
  logic [5:0][50:0] n_or;
  logic [6:0][50:0] n_and, n_xor;
  assign t[1]   = sat[0];
  assign x_d[0] = sat[0];
  for (genvar k = 2; k < 8; k++) begin : g_or
    OR2 u_o (.a(t[k-1]), .b(sat[k-1]), .y(t[k]), .number(n_or[k-2]));
  end
  for (genvar k = 1; k < 8; k++) begin : g_neg
    AND2 u_a (.a(neg1),   .b(t[k]),    .y(flip[k]), .number(n_and[k-1]));
    XOR2 u_x (.a(sat[k]), .b(flip[k]), .y(x_d[k]),  .number(n_xor[k-1]));
  end

  REGP #(.W(8)) u_s2 (
    .clk(clk), .rst_n(rst_n), .d(x_d), .q(bus.o_x), .number(n_reg[2])
  );

  // ---------------- transistor total ----------------
  always_comb begin
    number = '0;
    for (int i = 0; i < 16; i++) number += n_fold[i];
    for (int i = 0; i < 7;  i++) number += n_s1[i];
    for (int i = 0; i < 5;  i++) number += n_s2[i];
    for (int i = 0; i < 8;  i++) number += n_mab[i] + n_mc[i] + n_sat[i];
    for (int i = 0; i < 6;  i++) number += n_or[i];
    for (int i = 0; i < 7;  i++) number += n_and[i] + n_xor[i];
    for (int i = 0; i < 3;  i++) number += n_reg[i];
  end
endmodule

// ---------------- cell library ----------------
// Each cell reports its own transistor count on `number`.

// FD2: D flip-flop, rising edge, asynchronous active-low clear.
module FD2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d,
  output logic        q,
  output logic [50:0] number
);
  assign number = 51'd32;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end
endmodule

// REGP: W-bit bank of FD2 cells; count is the sum of its flops.
module REGP #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [50:0]  number
);
  logic [W-1:0][50:0] n_bit;
  for (genvar i = 0; i < W; i++) begin : g_ff
    FD2 u_ff (.clk(clk), .rst_n(rst_n), .d(d[i]), .q(q[i]), .number(n_bit[i]));
  end
  always_comb begin
    number = '0;
    for (int i = 0; i < W; i++) number += n_bit[i];
  end
endmodule

module INV (input logic a, output logic y, output logic [50:0] number);
  assign number = 51'd2;
  assign y = ~a;
endmodule

module NAND2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign number = 51'd4;
  assign y = ~(a & b);
endmodule

module AND2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign number = 51'd6;
  assign y = a & b;
endmodule

module OR2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign number = 51'd6;
  assign y = a | b;
endmodule

module XOR2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign number = 51'd12;
  assign y = a ^ b;
endmodule

module XNOR2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign number = 51'd12;
  assign y = ~(a ^ b);
endmodule

// MUX2: y = s ? b : a
module MUX2 (input logic a, input logic b, input logic s, output logic y,
             output logic [50:0] number);
  assign number = 51'd12;
  assign y = s ? b : a;
endmodule

// File: tb/tb_logit.sv
// tb_logit: scoreboard bench for logit. The driver pushes the hand-computed
// result and the cycle it is due; a monitor pops on every o_out_valid and
// also flags results that never appear.
module tb_logit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [50:0] number;

  logit_if bus();
  logit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .number(number));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  x;
    int          due;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Cell sum: 29 FD2 x32 = 928; 16 XNOR2 x12 = 192; 23 MUX2 x12 = 276;
  // 7 XOR2 x12 = 84; 13 AND2 x6 = 78; 7 OR2 x6 = 42; 5 INV x2 = 10;
  // 1 NAND2 x4 = 4. Total 1614.
  localparam logic [50:0] NUM_EXP = 51'd1614;

  logic [15:0] vy [13] = '{16'h8000, 16'hA000, 16'hC000, 16'hEC00,
                           16'h3FFF, 16'h5FFF, 16'h7FFF, 16'hFFFF,
                           16'h0000, 16'hF800, 16'hBFFF, 16'hEBFF,
                           16'h13FF};
  logic [7:0]  vx [13] = '{8'h00, 8'h10, 8'h20, 8'h50,
                           8'hE0, 8'hF0, 8'h00, 8'h7F,
                           8'h80, 8'h7F, 8'h1F, 8'h4B,
                           8'hB0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Present vector i for one cycle; result due two edges later.
  task automatic issue(input int i);
    @(negedge clk);
    bus.i_y        = vy[i];
    bus.i_in_valid = 1'b1;
    sb.push_back(exp_t'{vy[i], vx[i], cyc + 2});
  endtask

  // Idle cycles with junk on i_y, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_in_valid = 1'b0;
      bus.i_y        = 16'($urandom);
    end
  endtask

  initial begin
    bus.i_in_valid = 1'b0;
    bus.i_y        = 16'h0;

    fork
      begin : mon
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (bus.o_out_valid) begin
              n_cmp++;
              if (sb.size() == 0) begin
                n_err++;
                $display("FAIL extra_valid: got o_out_valid=1 x=%h at cycle %0d, required no output",
                         bus.o_x, cyc);
              end else begin
                e = sb.pop_front();
                if (bus.o_x !== e.x || e.due != cyc) begin
                  n_err++;
                  $display("FAIL result y=%h: got x=%h at cycle %0d, required x=%h at cycle %0d",
                           e.y, bus.o_x, cyc, e.x, e.due);
                end
              end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
              e = sb.pop_front();
              n_cmp++;
              n_err++;
              $display("FAIL missing y=%h: got no output by cycle %0d, required x=%h at cycle %0d",
                       e.y, cyc, e.x, e.due);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(bus.o_out_valid), 64'd0);
    chk("reset_x", 64'(bus.o_x), 64'd0);
    chk("number_reset", 64'(number), 64'(NUM_EXP));
    rst_n = 1'b1;
    idle(2);

    // Isolated samples, one every 4 cycles
    for (int i = 0; i < 13; i++) begin
      issue(i);
      idle(3);
    end

    // Streaming: 8 back-to-back, one bubble, 2 more
    for (int i = 0; i < 8; i++) issue(i);
    idle(1);
    issue(8);
    issue(9);
    idle(4);

    // Asynchronous reset with two results in flight
    issue(10);
    issue(11);
    @(posedge clk);
    #1;
    chk("inflight_valid", 64'(bus.o_out_valid), 64'd1);
    #1;
    rst_n          = 1'b0;
    bus.i_in_valid = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", 64'(bus.o_out_valid), 64'd0);
    chk("async_rst_x", 64'(bus.o_x), 64'd0);
    chk("number_in_reset", 64'(number), 64'(NUM_EXP));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    // Function after reset
    issue(12);
    idle(3);
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    idle(2);
    chk("drain", 64'(sb.size()), 64'd0);
    chk("number_end", 64'(number), 64'(NUM_EXP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
